// File: rtl/mountaincar_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mountaincar_pkg: shared action codes, FSM states and start-position ROM.
// Rev 1.0
// ----------------------------------------------------------------------------
package mountaincar_pkg;

  localparam logic [1:0] ACT_LEFT  = 2'd0;
  localparam logic [1:0] ACT_NONE  = 2'd1;
  localparam logic [1:0] ACT_RIGHT = 2'd2;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_OBS  = 3'd1,
    ST_ACT  = 3'd2,
    ST_CORE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Entry i = -0.6 + i*(0.2/15), fp32 round-to-nearest; listed from index 15 down to 0.
  localparam logic [15:0][31:0] START_ROM = {
    32'hBECCCCCD, 32'hBED3A06D, 32'hBEDA740E, 32'hBEE147AE,
    32'hBEE81B4F, 32'hBEEEEEEF, 32'hBEF5C28F, 32'hBEFC9630,
    32'hBF01B4E8, 32'hBF051EB8, 32'hBF088889, 32'hBF0BF259,
    32'hBF0F5C29, 32'hBF12C5F9, 32'hBF162FC9, 32'hBF19999A
  };

endpackage
`default_nettype wire

// File: rtl/mc_start_lfsr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_start_lfsr: free-running 16-bit Galois LFSR selecting a start position.
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_start_lfsr
  import mountaincar_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_start_pos
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_start_pos = START_ROM[lfsr_q[3:0]];

endmodule
`default_nettype wire

// File: rtl/mountaincar_episode_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mountaincar_episode_ctrl: episode sequencer around the MountainCar core.
// Rev 1.0 -- random start positions selectable with MC_RANDOM_START_EN.
// ----------------------------------------------------------------------------
module mountaincar_episode_ctrl
  import mountaincar_pkg::*;
#(
  parameter int                POS_WL       = 32,
  parameter int                VEL_WL       = 32,
  parameter int                ACT_WL       = 2,
  parameter int                MAX_STEPS    = 200,
  parameter int                CORE_TIMEOUT = 1023,
  parameter logic [POS_WL-1:0] INIT_POS     = 32'hBF000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_obs_valid,
  input  logic              i_obs_ready,
  output logic [POS_WL-1:0] o_obs_pos,
  output logic [VEL_WL-1:0] o_obs_vel,
  output logic              o_obs_done,
  output logic              o_obs_trunc,
  input  logic              i_act_valid,
  output logic              o_act_ready,
  input  logic [ACT_WL-1:0] i_act,
  output logic              o_core_ena,
  output logic [POS_WL-1:0] o_core_pos,
  output logic [VEL_WL-1:0] o_core_vel,
  output logic [ACT_WL-1:0] o_core_act,
  input  logic [POS_WL-1:0] i_core_pos,
  input  logic [VEL_WL-1:0] i_core_vel,
  input  logic              i_core_done,
  input  logic              i_core_valid,
  output logic [7:0]        o_step_cnt,
  output logic [15:0]       o_ep_cnt,
  output logic              o_err
);

  localparam int TMO_W = $clog2(CORE_TIMEOUT + 1);

  logic [POS_WL-1:0] w_start_pos;

`ifdef MC_RANDOM_START_EN
  logic [31:0] w_rom_pos;

  mc_start_lfsr u_start_lfsr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_start_pos (w_rom_pos)
  );

  assign w_start_pos = POS_WL'(w_rom_pos);
`else
  assign w_start_pos = INIT_POS;
`endif

  state_e            state_q, state_d;
  logic [POS_WL-1:0] pos_q, pos_d;
  logic [VEL_WL-1:0] vel_q, vel_d;
  logic [ACT_WL-1:0] act_q, act_d;
  logic [7:0]        step_cnt_q, step_cnt_d;
  logic [15:0]       ep_cnt_q, ep_cnt_d;
  logic              done_q, done_d;
  logic              trunc_q, trunc_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        w_step_inc;

  assign w_step_inc = step_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    vel_d       = vel_q;
    act_d       = act_q;
    step_cnt_d  = step_cnt_q;
    ep_cnt_d    = ep_cnt_q;
    done_d      = done_q;
    trunc_d     = trunc_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    o_obs_valid = 1'b0;
    o_act_ready = 1'b0;
    o_core_ena  = 1'b0;

    case (state_q)
      ST_INIT: begin
        pos_d      = w_start_pos;
        vel_d      = VEL_WL'(FP32_ZERO);
        step_cnt_d = 8'd0;
        done_d     = 1'b0;
        trunc_d    = 1'b0;
        state_d    = ST_OBS;
      end
      ST_OBS: begin
        o_obs_valid = 1'b1;
        if (i_obs_ready) begin
          if (done_q || trunc_q) begin
            ep_cnt_d = ep_cnt_q + 16'd1;
            state_d  = ST_INIT;
          end else begin
            state_d = ST_ACT;
          end
        end
      end
      ST_ACT: begin
        o_act_ready = 1'b1;
        if (i_act_valid) begin
          // The all-ones code is undefined and is treated as "no push"
          act_d   = (i_act == {ACT_WL{1'b1}}) ? ACT_WL'(ACT_NONE) : i_act;
          tmo_d   = '0;
          state_d = ST_CORE;
        end
      end
      ST_CORE: begin
        o_core_ena = 1'b1;
        if (i_core_valid) begin
          pos_d      = i_core_pos;
          vel_d      = i_core_vel;
          step_cnt_d = w_step_inc;
          done_d     = i_core_done;
          trunc_d    = (w_step_inc == 8'(MAX_STEPS)) && !i_core_done;
          state_d    = ST_OBS;
        end else if (tmo_q == TMO_W'(CORE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_INIT;
      pos_q      <= '0;
      vel_q      <= '0;
      act_q      <= '0;
      step_cnt_q <= 8'd0;
      ep_cnt_q   <= 16'd0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      vel_q      <= vel_d;
      act_q      <= act_d;
      step_cnt_q <= step_cnt_d;
      ep_cnt_q   <= ep_cnt_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign o_obs_pos   = pos_q;
  assign o_obs_vel   = vel_q;
  assign o_obs_done  = done_q;
  assign o_obs_trunc = trunc_q;
  assign o_core_pos  = pos_q;
  assign o_core_vel  = vel_q;
  assign o_core_act  = act_q;
  assign o_step_cnt  = step_cnt_q;
  assign o_ep_cnt    = ep_cnt_q;
  assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mountaincar_episode_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mountaincar_episode_ctrl: randomized episodes against an episode-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mountaincar_episode_ctrl;

  localparam logic [31:0] C_INIT_POS  = 32'hBF000000;
  localparam int          C_MAX_STEPS = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obs_valid, obs_ready, obs_done, obs_trunc;
  logic [31:0] obs_pos, obs_vel;
  logic        act_valid, act_ready;
  logic [1:0]  act;
  logic        core_ena, core_done_in, core_valid;
  logic [31:0] core_pos, core_vel, core_pos_in, core_vel_in;
  logic [1:0]  core_act;
  logic [7:0]  step_cnt;
  logic [15:0] ep_cnt;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  // Episode-level reference state
  logic [31:0] m_pos, m_vel;
  int          m_step, m_ep;
  bit          m_done, m_trunc;
  bit          first_bp = 1'b1;

  mountaincar_episode_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_obs_valid  (obs_valid),
    .i_obs_ready  (obs_ready),
    .o_obs_pos    (obs_pos),
    .o_obs_vel    (obs_vel),
    .o_obs_done   (obs_done),
    .o_obs_trunc  (obs_trunc),
    .i_act_valid  (act_valid),
    .o_act_ready  (act_ready),
    .i_act        (act),
    .o_core_ena   (core_ena),
    .o_core_pos   (core_pos),
    .o_core_vel   (core_vel),
    .o_core_act   (core_act),
    .i_core_pos   (core_pos_in),
    .i_core_vel   (core_vel_in),
    .i_core_done  (core_done_in),
    .i_core_valid (core_valid),
    .o_step_cnt   (step_cnt),
    .o_ep_cnt     (ep_cnt),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_new_episode();
    m_pos   = C_INIT_POS;
    m_vel   = 32'h0;
    m_step  = 0;
    m_done  = 1'b0;
    m_trunc = 1'b0;
  endtask

  task automatic check_obs_payload(input string tag);
    check_eq({tag, "_pos"},   obs_pos,   m_pos);
    check_eq({tag, "_vel"},   obs_vel,   m_vel);
    check_eq({tag, "_done"},  obs_done,  m_done);
    check_eq({tag, "_trunc"}, obs_trunc, m_trunc);
    check_eq({tag, "_step"},  step_cnt,  m_step[7:0]);
    check_eq({tag, "_ep"},    ep_cnt,    m_ep[15:0]);
  endtask

  // One observation, and unless the episode ends, one action and one core step.
  task automatic run_step(input int done_at, input bit silent, output bit ended);
    int          n;
    int          bp;
    int          lat;
    logic [1:0]  a;
    logic [31:0] npos, nvel;
    bit          d;

    n = 0;
    while (!obs_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("obs_wait", obs_valid, 1'b1);
    check_obs_payload("obs");

    bp = first_bp ? 10 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0);
    first_bp = 1'b0;
    for (int i = 0; i < bp; i++) begin
      core_valid  = 1'b1;
      core_pos_in = $urandom;
      core_vel_in = $urandom;
      @(negedge clk);
      check_eq("bp_valid", obs_valid, 1'b1);
      check_eq("bp_pos", obs_pos, m_pos);
      check_eq("bp_vel", obs_vel, m_vel);
      check_eq("bp_act_ready", act_ready, 1'b0);
    end
    core_valid = 1'b0;

    obs_ready = 1'b1;
    @(negedge clk);
    obs_ready = 1'b0;
    check_eq("obs_drop", obs_valid, 1'b0);

    if (m_done || m_trunc) begin
      m_ep++;
      model_new_episode();
      ended = 1'b1;
      return;
    end
    ended = 1'b0;

    n = 0;
    while (!act_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("act_ready", act_ready, 1'b1);
    check_eq("act_vs_obs", obs_valid, 1'b0);

    a = 2'($urandom_range(0, 3));
    act_valid = 1'b1;
    act       = a;
    @(negedge clk);
    act_valid = 1'b0;
    act       = 2'($urandom);
    check_eq("core_ena_rise", core_ena, 1'b1);
    check_eq("core_pos", core_pos, m_pos);
    check_eq("core_vel", core_vel, m_vel);
    check_eq("core_act", core_act, (a == 2'd3) ? 2'd1 : a);
    check_eq("act_ready_off", act_ready, 1'b0);
    if (silent) return;

    lat = $urandom_range(0, 6);
    repeat (lat) @(negedge clk);
    npos = $urandom;
    nvel = $urandom;
    d    = (m_step + 1 == done_at);
    core_valid   = 1'b1;
    core_pos_in  = npos;
    core_vel_in  = nvel;
    core_done_in = d;
    @(negedge clk);
    core_valid   = 1'b0;
    core_pos_in  = $urandom;
    core_vel_in  = $urandom;
    core_done_in = 1'($urandom);
    check_eq("core_ena_fall", core_ena, 1'b0);

    m_step++;
    m_pos   = npos;
    m_vel   = nvel;
    m_done  = d;
    m_trunc = (m_step == C_MAX_STEPS) && !d;
  endtask

  initial begin
    bit ended;

    rst_n        = 1'b0;
    obs_ready    = 1'b0;
    act_valid    = 1'b0;
    act          = 2'd0;
    core_valid   = 1'b0;
    core_done_in = 1'b0;
    core_pos_in  = 32'h0;
    core_vel_in  = 32'h0;
    m_ep         = 0;
    model_new_episode();

    repeat (3) @(negedge clk);
    check_eq("rst_obs_valid", obs_valid, 1'b0);
    check_eq("rst_act_ready", act_ready, 1'b0);
    check_eq("rst_core_ena", core_ena, 1'b0);
    check_eq("rst_obs_pos", obs_pos, 32'h0);
    check_eq("rst_core_pos", core_pos, 32'h0);
    check_eq("rst_vel", obs_vel, 32'h0);
    check_eq("rst_act", core_act, 2'd0);
    check_eq("rst_step", step_cnt, 8'd0);
    check_eq("rst_ep", ep_cnt, 16'd0);
    check_eq("rst_err", err, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_obs_valid", obs_valid, 1'b1);
    check_obs_payload("first_obs");

    // Episode 0 reaches the goal on step 37; episode 1 runs into truncation
    for (int ep = 0; ep < 2; ep++) begin
      ended = 1'b0;
      while (!ended) run_step((ep == 0) ? 37 : 0, 1'b0, ended);
      check_eq("ep_count_model", ep_cnt, m_ep[15:0]);
    end

    for (int s = 0; s < 3; s++) run_step(0, 1'b0, ended);
    run_step(0, 1'b1, ended);

    repeat (1000) @(negedge clk);
    check_eq("tmo_not_yet", err, 1'b0);
    check_eq("tmo_ena_held", core_ena, 1'b1);
    repeat (30) @(negedge clk);
    check_eq("tmo_err", err, 1'b1);
    check_eq("tmo_obs_valid", obs_valid, 1'b0);
    check_eq("tmo_act_ready", act_ready, 1'b0);
    check_eq("tmo_core_ena", core_ena, 1'b0);

    rst_n      = 1'b0;
    core_valid = 1'b1;
    #1;
    check_eq("rst2_err", err, 1'b0);
    check_eq("rst2_step", step_cnt, 8'd0);
    check_eq("rst2_ep", ep_cnt, 16'd0);
    check_eq("rst2_core_ena", core_ena, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ep  = 0;
    model_new_episode();
    @(negedge clk);
    core_valid = 1'b0;
    check_eq("rst2_obs_valid", obs_valid, 1'b1);
    check_obs_payload("rst2_obs");

    for (int s = 0; s < 2; s++) run_step(0, 1'b0, ended);
    run_step(0, 1'b0, ended);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
